sram_arbiter: RTL and testbench

- Shares one asynchronous external SRAM (active-low EN/OE/WE, 18-bit address, 16-bit bidirectional data) between two requesters: port 0 (data/memory stage) and port 1 (instruction fetch).
- Accepts one request at a time over a valid/ready handshake.
- Sequences the SRAM strobes with a programmable wait count, then returns a one-cycle response pulse to the granted port.
- Sits between the core's memory interfaces and the board SRAM pins.

---
 rtl/sram_ctrl_pkg.sv | 18 +
 rtl/sram_arbiter_if.sv | 38 +++
 rtl/rr_arb2.sv | 20 ++
 rtl/sram_arbiter.sv | 139 +++++++++++++
 tb/tb_sram_arbiter.sv | 308 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/sram_ctrl_pkg.sv
// Shared definitions for the two-port SRAM arbiter: FSM state encoding,
// default bus widths and requester port indices.
package sram_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SETUP   = 2'd1,
        ACCESS  = 2'd2,
        RELEASE = 2'd3
    } state_t;

    localparam int DEF_ADDR_W = 18;
    localparam int DEF_DATA_W = 16;

    localparam logic PORT_DATA = 1'b0;
    localparam logic PORT_INST = 1'b1;

endpackage

// File: rtl/sram_arbiter_if.sv
// Requester-side bundle of the SRAM arbiter: two valid/ready request ports
// (data stage and instruction fetch) with their response pulses.
interface sram_arbiter_if
    import sram_ctrl_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
);
    logic              p0_req;
    logic              p0_we;
    logic [ADDR_W-1:0] p0_addr;
    logic [DATA_W-1:0] p0_wdata;
    logic              p0_ready;
    logic              p0_rvalid;
    logic [DATA_W-1:0] p0_rdata;

    logic              p1_req;
    logic              p1_we;
    logic [ADDR_W-1:0] p1_addr;
    logic [DATA_W-1:0] p1_wdata;
    logic              p1_ready;
    logic              p1_rvalid;
    logic [DATA_W-1:0] p1_rdata;

    modport master (
        output p0_req, p0_we, p0_addr, p0_wdata,
        input  p0_ready, p0_rvalid, p0_rdata,
        output p1_req, p1_we, p1_addr, p1_wdata,
        input  p1_ready, p1_rvalid, p1_rdata
    );

    modport slave (
        input  p0_req, p0_we, p0_addr, p0_wdata,
        output p0_ready, p0_rvalid, p0_rdata,
        input  p1_req, p1_we, p1_addr, p1_wdata,
        output p1_ready, p1_rvalid, p1_rdata
    );
endinterface

// File: rtl/rr_arb2.sv
// Combinational two-way round-robin grant; the last-grant pointer is kept
// by the caller so the grant can be committed only on an actual accept.
module rr_arb2
    import sram_ctrl_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last_grant,
    output logic       gnt_valid,
    output logic       gnt_port
);
    always_comb begin
        gnt_valid = |req;
        gnt_port  = PORT_DATA;
        if (req == 2'b11) begin
            gnt_port = ~last_grant;
        end else if (req[1]) begin
            gnt_port = PORT_INST;
        end
    end
endmodule

// File: rtl/sram_arbiter.sv
// Two-requester arbiter for an asynchronous SRAM: accepts one request at a
// time, sequences EN/OE/WE through SETUP/ACCESS/RELEASE, pulses rvalid.
module sram_arbiter
    import sram_ctrl_pkg::*;
#(
    parameter int ADDR_W      = DEF_ADDR_W,
    parameter int DATA_W      = DEF_DATA_W,
    parameter int WAIT_CYCLES = 1
) (
    input  logic              clk,
    input  logic              rst,
    sram_arbiter_if.slave     bus,
    output logic              ram_en,
    output logic              ram_oe,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    inout  wire  [DATA_W-1:0] ram_data,
    output logic              busy
);
    localparam logic [3:0] WAIT_LD = 4'(WAIT_CYCLES);

    state_t            state;
    state_t            state_nxt;
    logic [3:0]        cnt;
    logic              last_grant;
    logic              port_q;
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] rdata0;
    logic [DATA_W-1:0] rdata1;

    logic              gnt_valid;
    logic              gnt_port;
    logic              accept;
    logic              take;
    logic              last_access;
    logic              drive;

    rr_arb2 u_arb (
        .req        ({bus.p1_req, bus.p0_req}),
        .last_grant (last_grant),
        .gnt_valid  (gnt_valid),
        .gnt_port   (gnt_port)
    );

    // Accept is suppressed under reset so ready never shows while rst is high.
    assign take        = accept && !rst;
    assign last_access = (state == ACCESS) && (cnt == 4'd1);

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= 4'd0;
            last_grant <= PORT_INST;
            addr_q     <= '0;
            rdata0     <= '0;
            rdata1     <= '0;
        end else begin
            state <= state_nxt;
            if (state == SETUP) begin
                cnt <= WAIT_LD;
            end else if (state == ACCESS) begin
                cnt <= cnt - 4'd1;
            end
            if (take) begin
                last_grant <= gnt_port;
                addr_q     <= gnt_port ? bus.p1_addr : bus.p0_addr;
            end
            // Read data is sampled while OE is still low on the final ACCESS edge.
            if (last_access && !we_q) begin
                if (port_q == PORT_INST) begin
                    rdata1 <= ram_data;
                end else begin
                    rdata0 <= ram_data;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (take) begin
            port_q  <= gnt_port;
            we_q    <= gnt_port ? bus.p1_we    : bus.p0_we;
            wdata_q <= gnt_port ? bus.p1_wdata : bus.p0_wdata;
        end
    end

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        ram_en    = 1'b1;
        ram_oe    = 1'b1;
        ram_we    = 1'b1;
        drive     = 1'b0;
        case (state)
            IDLE: begin
                if (gnt_valid) begin
                    accept    = 1'b1;
                    state_nxt = SETUP;
                end
            end
            SETUP: begin
                ram_en    = 1'b0;
                ram_oe    = we_q;
                drive     = we_q;
                state_nxt = ACCESS;
            end
            ACCESS: begin
                ram_en = 1'b0;
                ram_oe = we_q;
                ram_we = !we_q;
                drive  = we_q;
                if (cnt == 4'd1) begin
                    state_nxt = RELEASE;
                end
            end
            RELEASE: begin
                // Strobes rise here while data and address stay put for hold time.
                ram_en    = 1'b0;
                drive     = we_q;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign busy     = (state != IDLE);
    assign ram_addr = addr_q;
    assign ram_data = drive ? wdata_q : 'z;

    assign bus.p0_ready  = take && (gnt_port == PORT_DATA);
    assign bus.p1_ready  = take && (gnt_port == PORT_INST);
    assign bus.p0_rvalid = (state == RELEASE) && (port_q == PORT_DATA);
    assign bus.p1_rvalid = (state == RELEASE) && (port_q == PORT_INST);
    assign bus.p0_rdata  = rdata0;
    assign bus.p1_rdata  = rdata1;

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed bench for sram_arbiter: two instances (WAIT_CYCLES 1 and 3), each
// with a behavioural SRAM on a pulled-up data bus.
module tb_sram_arbiter;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    sram_arbiter_if #(.ADDR_W(18), .DATA_W(16)) bus ();
    sram_arbiter_if #(.ADDR_W(18), .DATA_W(16)) bus3 ();

    logic        ram_en, ram_oe, ram_we, busy;
    logic [17:0] ram_addr;
    wire  [15:0] ram_data;
    logic        ram_en3, ram_oe3, ram_we3, busy3;
    logic [17:0] ram_addr3;
    wire  [15:0] ram_data3;

    // Undriven bus reads back as all ones.
    pullup (ram_data);
    pullup (ram_data3);

    sram_arbiter #(.ADDR_W(18), .DATA_W(16), .WAIT_CYCLES(1)) u_dut (
        .clk(clk), .rst(rst), .bus(bus),
        .ram_en(ram_en), .ram_oe(ram_oe), .ram_we(ram_we),
        .ram_addr(ram_addr), .ram_data(ram_data), .busy(busy)
    );

    sram_arbiter #(.ADDR_W(18), .DATA_W(16), .WAIT_CYCLES(3)) u_dut3 (
        .clk(clk), .rst(rst), .bus(bus3),
        .ram_en(ram_en3), .ram_oe(ram_oe3), .ram_we(ram_we3),
        .ram_addr(ram_addr3), .ram_data(ram_data3), .busy(busy3)
    );

    logic [15:0] mem [0:255];
    assign ram_data = (!ram_en && !ram_oe) ? mem[ram_addr[7:0]] : 'z;
    always @(posedge clk) begin
        if (!ram_en && !ram_we) mem[ram_addr[7:0]] <= ram_data;
    end

    // Second SRAM returns an address-derived pattern.
    assign ram_data3 = (!ram_en3 && !ram_oe3) ? (ram_addr3[15:0] ^ 16'h5A5A) : 'z;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    logic [15:0] ref_mem [0:15];
    logic        ref_ok  [0:15];

    initial begin
        int   n;
        logic g;
        int   acc, cyc, age;
        logic pend, pport, pchk, drop0, drop1;
        logic [15:0] pexp;
        logic [3:0]  a;

        rst = 1'b1;
        bus.p0_req = 0; bus.p0_we = 0; bus.p0_addr = '0; bus.p0_wdata = '0;
        bus.p1_req = 0; bus.p1_we = 0; bus.p1_addr = '0; bus.p1_wdata = '0;
        bus3.p0_req = 0; bus3.p0_we = 0; bus3.p0_addr = '0; bus3.p0_wdata = '0;
        bus3.p1_req = 0; bus3.p1_we = 0; bus3.p1_addr = '0; bus3.p1_wdata = '0;
        tick();
        tick();

        chk("rst_en", ram_en, 1);
        chk("rst_oe", ram_oe, 1);
        chk("rst_we", ram_we, 1);
        chk("rst_addr", ram_addr, 0);
        chk("rst_data_z", ram_data, 16'hFFFF);
        chk("rst_ready", {bus.p0_ready, bus.p1_ready}, 0);
        chk("rst_rvalid", {bus.p0_rvalid, bus.p1_rvalid}, 0);
        chk("rst_rdata", {bus.p0_rdata, bus.p1_rdata}, 0);
        chk("rst_busy", busy, 0);
        rst = 1'b0;

        // Port-0 write of 0xBEEF to 0x10
        bus.p0_req = 1; bus.p0_we = 1; bus.p0_addr = 18'h10; bus.p0_wdata = 16'hBEEF;
        #1;
        chk("w_ready0", bus.p0_ready, 1);
        chk("w_ready1", bus.p1_ready, 0);
        tick();
        bus.p0_req = 0;
        chk("w_setup_en", ram_en, 0);
        chk("w_setup_we", ram_we, 1);
        chk("w_setup_oe", ram_oe, 1);
        chk("w_setup_data", ram_data, 16'hBEEF);
        chk("w_setup_addr", ram_addr, 18'h10);
        chk("w_setup_busy", busy, 1);
        tick();
        chk("w_acc_we", ram_we, 0);
        chk("w_acc_oe", ram_oe, 1);
        chk("w_acc_data", ram_data, 16'hBEEF);
        chk("w_acc_rvalid", bus.p0_rvalid, 0);
        tick();
        chk("w_rel_we", ram_we, 1);
        chk("w_rel_en", ram_en, 0);
        chk("w_rel_data", ram_data, 16'hBEEF);
        chk("w_rel_rvalid", {bus.p1_rvalid, bus.p0_rvalid}, 2'b01);
        tick();
        chk("w_idle_en", ram_en, 1);
        chk("w_idle_data_z", ram_data, 16'hFFFF);
        chk("w_idle_rvalid", bus.p0_rvalid, 0);
        chk("w_idle_busy", busy, 0);
        chk("w_idle_addr", ram_addr, 18'h10);

        // Port-1 read back of 0x10
        bus.p1_req = 1; bus.p1_we = 0; bus.p1_addr = 18'h10;
        #1;
        chk("r_ready1", bus.p1_ready, 1);
        chk("r_ready0", bus.p0_ready, 0);
        tick();
        bus.p1_req = 0;
        chk("r_setup_oe", ram_oe, 0);
        chk("r_setup_we", ram_we, 1);
        chk("r_setup_data", ram_data, 16'hBEEF);
        tick();
        chk("r_acc_oe", ram_oe, 0);
        chk("r_acc_we", ram_we, 1);
        tick();
        chk("r_rel_oe", ram_oe, 1);
        chk("r_rel_rvalid", {bus.p1_rvalid, bus.p0_rvalid}, 2'b10);
        chk("r_rel_rdata1", bus.p1_rdata, 16'hBEEF);
        chk("r_rdata0_untouched", bus.p0_rdata, 0);
        tick();
        chk("r_idle_rvalid", bus.p1_rvalid, 0);
        chk("r_hold_rdata1", bus.p1_rdata, 16'hBEEF);

        // Both ports requesting continuously from reset: grants alternate 0,1,0,1
        rst = 1;
        bus.p0_req = 1; bus.p0_we = 0; bus.p0_addr = 18'h20;
        bus.p1_req = 1; bus.p1_we = 0; bus.p1_addr = 18'h30;
        tick();
        rst = 0;
        for (int k = 0; k < 4; k++) begin
            n = 0;
            #1;
            while (!(bus.p0_ready || bus.p1_ready) && n < 10) begin
                tick();
                #1;
                n++;
            end
            chk("rr_wait", (n < 10) ? 1 : 0, 1);
            g = bus.p1_ready;
            chk("rr_grant", g, k % 2);
            chk("rr_both", bus.p0_ready & bus.p1_ready, 0);
            tick();
            chk("rr_ready_1cyc", {bus.p0_ready, bus.p1_ready}, 0);
            tick();
            tick();
            chk("rr_rvalid", {bus.p1_rvalid, bus.p0_rvalid}, g ? 2'b10 : 2'b01);
            tick();
        end
        bus.p0_req = 0;
        bus.p1_req = 0;

        // WAIT_CYCLES=3 instance: back-to-back port-0 reads
        bus3.p0_req = 1; bus3.p0_we = 0; bus3.p0_addr = 18'h44;
        #1;
        chk("w3_ready_a", bus3.p0_ready, 1);
        tick();
        bus3.p0_addr = 18'h45;
        n = 1;
        while (!bus3.p0_rvalid && n < 20) begin
            tick();
            n++;
        end
        chk("w3_lat_a", n, 5);
        chk("w3_rdata_a", bus3.p0_rdata, 16'h5A1E);
        chk("w3_ready_rel", bus3.p0_ready, 0);
        tick();
        #1;
        chk("w3_ready_b", bus3.p0_ready, 1);
        tick();
        bus3.p0_req = 0;
        n = 1;
        while (!bus3.p0_rvalid && n < 20) begin
            tick();
            n++;
        end
        chk("w3_lat_b", n, 5);
        chk("w3_rdata_b", bus3.p0_rdata, 16'h5A1F);
        tick();

        // Reset during ACCESS of a write
        bus.p0_req = 1; bus.p0_we = 1; bus.p0_addr = 18'h50; bus.p0_wdata = 16'h1234;
        #1;
        chk("ab_ready0", bus.p0_ready, 1);
        tick();
        bus.p0_req = 0;
        tick();
        chk("ab_pre_we", ram_we, 0);
        rst = 1;
        tick();
        chk("ab_we", ram_we, 1);
        chk("ab_en", ram_en, 1);
        chk("ab_oe", ram_oe, 1);
        chk("ab_data_z", ram_data, 16'hFFFF);
        chk("ab_rvalid", {bus.p0_rvalid, bus.p1_rvalid}, 0);
        chk("ab_busy", busy, 0);
        rst = 0;
        tick();
        chk("ab_rvalid_after", {bus.p0_rvalid, bus.p1_rvalid}, 0);
        bus.p0_req = 1; bus.p0_we = 0; bus.p0_addr = 18'h20;
        bus.p1_req = 1; bus.p1_we = 0; bus.p1_addr = 18'h10;
        #1;
        chk("ab_lastgrant", {bus.p1_ready, bus.p0_ready}, 2'b01);
        tick();
        bus.p0_req = 0;
        tick();
        tick();
        chk("ab_p0_rvalid", bus.p0_rvalid, 1);
        tick();
        #1;
        chk("ab_p1_ready", bus.p1_ready, 1);
        tick();
        bus.p1_req = 0;
        tick();
        tick();
        chk("ab_p1_rvalid", bus.p1_rvalid, 1);
        chk("ab_p1_rdata", bus.p1_rdata, 16'hBEEF);
        tick();

        // Random traffic with protocol checks and a read-back scoreboard
        for (int i = 0; i < 16; i++) begin
            ref_ok[i]  = 1'b0;
            ref_mem[i] = '0;
        end
        acc = 0; cyc = 0; age = 0;
        pend = 0; pport = 0; pchk = 0; pexp = '0;
        while (acc < 1000 && cyc < 20000) begin
            if (!bus.p0_req && $urandom_range(1) == 1) begin
                bus.p0_req   = 1;
                bus.p0_we    = 1'($urandom_range(1));
                bus.p0_addr  = 18'($urandom_range(15));
                bus.p0_wdata = 16'($urandom);
            end
            if (!bus.p1_req && $urandom_range(1) == 1) begin
                bus.p1_req   = 1;
                bus.p1_we    = 1'($urandom_range(1));
                bus.p1_addr  = 18'($urandom_range(15));
                bus.p1_wdata = 16'($urandom);
            end
            #1;
            chk("p_we_oe", ram_we | ram_oe, 1);
            chk("p_busy", busy, !ram_en);
            chk("p_rvalid_excl", bus.p0_rvalid & bus.p1_rvalid, 0);
            if (!ram_oe) chk("p_read_bus", ram_data, mem[ram_addr[7:0]]);
            if (bus.p0_rvalid || bus.p1_rvalid) begin
                chk("s_pending", pend, 1);
                chk("s_port", bus.p1_rvalid, pport);
                if (pchk) chk("s_rdata", pport ? bus.p1_rdata : bus.p0_rdata, pexp);
                pend = 0;
            end else if (pend) begin
                age++;
                if (age > 8) begin
                    chk("s_timeout", age, 8);
                    pend = 0;
                end
            end
            drop0 = bus.p0_ready;
            drop1 = bus.p1_ready;
            if (bus.p0_ready || bus.p1_ready) begin
                pport = bus.p1_ready;
                a = pport ? bus.p1_addr[3:0] : bus.p0_addr[3:0];
                if (pport ? bus.p1_we : bus.p0_we) begin
                    ref_mem[a] = pport ? bus.p1_wdata : bus.p0_wdata;
                    ref_ok[a]  = 1'b1;
                    pchk = 0;
                end else begin
                    pchk = ref_ok[a];
                    pexp = ref_mem[a];
                end
                pend = 1;
                age  = 0;
                acc++;
            end
            tick();
            if (drop0) bus.p0_req = 0;
            if (drop1) bus.p1_req = 0;
            cyc++;
        end
        chk("rand_accesses", acc, 1000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
